// File: rtl/posit_quire_accum_ctrl_if.sv
// Handshake bundle between the quire accumulation sequencer and its job source,
// element stream and result consumer.
interface posit_quire_accum_ctrl_if #(
  parameter int LEN_BITS          = 16,
  parameter int ADJUST_SCALE_SIZE = 8
) ();
  logic                         startValid;
  logic                         startReady;
  logic [LEN_BITS-1:0]          startLen;
  logic [ADJUST_SCALE_SIZE-1:0] startAdjust;
  logic                         inValid;
  logic                         inReady;
  logic                         quireClear;
  logic                         quireAddValid;
  logic [ADJUST_SCALE_SIZE-1:0] adjustScale;
  logic                         resultValid;
  logic                         resultReady;
  logic                         busy;
  logic [LEN_BITS-1:0]          count;

  modport master (
    output startValid, startLen, startAdjust, inValid, resultReady,
    input  startReady, inReady, quireClear, quireAddValid, adjustScale,
           resultValid, busy, count
  );

  modport slave (
    input  startValid, startLen, startAdjust, inValid, resultReady,
    output startReady, inReady, quireClear, quireAddValid, adjustScale,
           resultValid, busy, count
  );
endinterface

// File: rtl/posit_quire_accum_ctrl.sv
// Job sequencer for a shared posit-to-quire convert/add datapath: clear, stream
// N elements, wait out the adder pipeline, then hand the quire to the consumer.
module posit_quire_accum_ctrl #(
  parameter int LEN_BITS          = 16,
  parameter int ADD_LATENCY       = 3,
  parameter int ADJUST_SCALE_SIZE = 8
) (
  input  logic                   clock,
  input  logic                   resetn,
  posit_quire_accum_ctrl_if.slave bus
);

  localparam int DRAIN_BITS = (ADD_LATENCY < 2) ? 1 : $clog2(ADD_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, RESULT} state_t;

  state_t                       state, state_next;
  logic [LEN_BITS-1:0]          len;
  logic [LEN_BITS-1:0]          count_q;
  logic [DRAIN_BITS-1:0]        drain_cnt;
  logic [ADJUST_SCALE_SIZE-1:0] adjust_q;
  logic                         add_fire;
  logic                         last_elem;
  logic                         start_fire;

  assign start_fire = (state == IDLE) && bus.startValid;
  assign add_fire   = (state == ACCUM) && bus.inValid;
  assign last_elem  = (count_q == len - 1'b1);

  always_comb begin
    state_next      = state;
    bus.startReady  = 1'b0;
    bus.inReady     = 1'b0;
    bus.quireClear  = 1'b0;
    bus.resultValid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.startReady = 1'b1;
        if (bus.startValid) state_next = CLEAR;
      end
      CLEAR: begin
        bus.quireClear = 1'b1;
        state_next     = (len != '0) ? ACCUM : RESULT;
      end
      ACCUM: begin
        bus.inReady = 1'b1;
        if (add_fire && last_elem) state_next = (ADD_LATENCY == 0) ? RESULT : DRAIN;
      end
      DRAIN: begin
        // Leaving on the count of 1 keeps DRAIN exactly ADD_LATENCY cycles long.
        if (drain_cnt == DRAIN_BITS'(1)) state_next = RESULT;
      end
      RESULT: begin
        bus.resultValid = 1'b1;
        if (bus.resultReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      len       <= '0;
      count_q   <= '0;
      drain_cnt <= '0;
      adjust_q  <= '0;
    end else begin
      state <= state_next;
      if (start_fire) begin
        len      <= bus.startLen;
        adjust_q <= bus.startAdjust;
        count_q  <= '0;
      end
      if (add_fire) count_q <= count_q + 1'b1;
      if (add_fire && last_elem) drain_cnt <= DRAIN_BITS'(ADD_LATENCY);
      else if (state == DRAIN)   drain_cnt <= drain_cnt - 1'b1;
    end
  end

  assign bus.quireAddValid = add_fire;
  assign bus.adjustScale   = adjust_q;
  assign bus.count         = count_q;
  assign bus.busy          = (state != IDLE);

endmodule

// File: doc/posit_quire_accum_ctrl.md
Name: posit_quire_accum_ctrl

Overview:
Sequencer for one shared posit-to-quire accumulation datapath: a posit quire convert stage feeding a pipelined quire adder. It accepts a job of N elements, clears the quire, and streams N element handshakes into the datapath. It then waits out the adder pipeline latency and presents a result-ready handshake so the quire can be read and rounded. It also holds the per-job exponent adjust scale driven to the convert stage.

Parameters:
LEN_BITS, 16, width of the element count and length fields
ADD_LATENCY, 3, cycles from quireAddValid until the quire reflects that element (0 allowed)
ADJUST_SCALE_SIZE, 8, width of the signed per-job exponent adjust

Ports:
clock  in  1  rising-edge clock
resetn  in  1  synchronous active-low reset
startValid  in  1  job request
startReady  out  1  high only in IDLE
startLen  in  LEN_BITS  element count N (unsigned), sampled on start transfer
startAdjust  in  ADJUST_SCALE_SIZE  signed adjust scale, sampled on start transfer
inValid  in  1  upstream element valid (element data bypasses this block)
inReady  out  1  element accepted when inValid and inReady
quireClear  out  1  one-cycle pulse that zeroes the quire
quireAddValid  out  1  element enters convert/add datapath this cycle
adjustScale  out  ADJUST_SCALE_SIZE  registered startAdjust, held for the job
resultValid  out  1  quire holds the final sum
resultReady  in  1  consumer has read the quire
busy  out  1  state != IDLE
count  out  LEN_BITS  elements accepted in the current job

Behaviour:
- States: IDLE, CLEAR, ACCUM, DRAIN, RESULT. All state, count, drain counter and adjustScale are registered.
- Reset (resetn=0 at a clock edge): state=IDLE, count=0, drain counter=0, adjustScale=0. Resulting outputs: startReady=1; inReady, quireClear, quireAddValid, resultValid and busy=0.
- IDLE: startReady=1. On startValid, latch len=startLen and adjustScale=startAdjust, clear count to 0, and go to CLEAR.
- CLEAR (exactly 1 cycle): quireClear=1, inReady=0. Next state is ACCUM if len!=0. If len==0, next state is RESULT (the quire reads as zero).
- ACCUM: inReady=1. quireAddValid=inValid&&inReady (combinational, same cycle as the transfer). Each transfer increments count.
  - On the transfer where count==len-1: count becomes len, inReady drops the next cycle, and the next state is DRAIN with the drain counter loaded to ADD_LATENCY.
  - If ADD_LATENCY==0, the next state is RESULT instead.
  - Idle cycles (inValid=0) are allowed; there is no timeout.
- DRAIN: inReady=0. The drain counter decrements each cycle. The transition to RESULT happens on the cycle the counter is 1, so DRAIN lasts exactly ADD_LATENCY cycles.
- RESULT: resultValid=1, held until resultReady. On resultValid&&resultReady, go to IDLE.
  - count and adjustScale hold their values until the next start.
  - A new start can be accepted at the earliest on the cycle after that transfer (no same-cycle overlap).
- startValid outside IDLE is ignored, not queued. resultReady outside RESULT is ignored.
- count width: len up to 2^LEN_BITS-1. count never wraps, because acceptance stops at len.
- Reset mid-job: returns to IDLE with no quireClear pulse and no further quireAddValid. Quire contents are undefined, and the next job's CLEAR re-zeroes them.
- Latency, start to result (no input stalls): 1 (start) + 1 (CLEAR) + N (ACCUM) + ADD_LATENCY cycles.

Test Plan:
- N=4, ADD_LATENCY=3, inValid held high → quireClear for exactly 1 cycle; quireAddValid high for 4 consecutive cycles; DRAIN for 3 cycles; resultValid asserts 9 cycles after the start edge; count=4.
- N=0 → quireClear pulse, then resultValid the next cycle; quireAddValid never asserts; count=0.
- N=5 with inValid pattern 1,0,0,1,1,0,1,1 → exactly 5 quireAddValid pulses, aligned to the inValid=1 cycles; inReady=0 after the 5th.
- resultReady held low 10 cycles in RESULT → resultValid stays 1 and state holds; a startValid pulse there is ignored (startReady=0); resultReady=1 returns to IDLE.
- startAdjust=-3 (8'hFD) with N=2, then startAdjust=+7 with N=1 back-to-back → adjustScale=8'hFD for all of job 1 and 8'h07 from job 2's start; each job gets its own quireClear.
- resetn=0 during ACCUM at count=2 of N=6 → next cycle IDLE, count=0, inReady=0, quireAddValid=0; a new job with N=1 then completes normally.
- ADD_LATENCY=0 build, N=3 → RESULT on the cycle after the 3rd transfer; DRAIN never entered.
